// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall sequencer: detects RAW/load-use hazards, handles taken
// redirects, memory stalls and HALT, and counts stall cycles and redirects.
module hazard_stall_ctrl #(
  parameter int unsigned FORWARDING   = 1,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rs_valid,
  input  logic [2:0]       rs_sel,
  input  logic             rt_valid,
  input  logic [2:0]       rt_sel,
  input  logic             de_reg_write_en,
  input  logic [2:0]       de_write_reg_sel,
  input  logic             de_mem_read,
  input  logic             em_reg_write_en,
  input  logic [2:0]       em_write_reg_sel,
  input  logic             branch_taken_ex,
  input  logic             halt_ex,
  input  logic             imem_stall,
  input  logic             dmem_stall,
  output logic             stall_PC,
  output logic             stall_FD,
  output logic             flush_FD,
  output logic             insert_NOP,
  output logic             freeze_DE,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned    FC_W    = 2;
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_FLUSH  = 2'd1,
    S_FREEZE = 2'd2,
    S_HALT   = 2'd3
  } state_e;

  state_e           state_q, state_d, eff_state;
  logic             ret_flush_q, ret_flush_d;
  logic [FC_W-1:0]  fcnt_q, fcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             flush_inc;
  logic             stall_inc;
  logic             lu, raw;

  function automatic logic src_match(input logic [2:0] r);
    return (rs_valid && (rs_sel == r)) || (rt_valid && (rt_sel == r));
  endfunction

  // Hazard detection; Writeback producer is covered by write-through regfile
  always_comb begin
    lu  = de_reg_write_en && de_mem_read && src_match(de_write_reg_sel);
    raw = (FORWARDING != 0) ? lu
        : ((de_reg_write_en && src_match(de_write_reg_sel)) ||
           (em_reg_write_en && src_match(em_write_reg_sel)));
  end

  // Releasing FREEZE behaves as the saved state within the same cycle
  assign eff_state = ((state_q == S_FREEZE) && !dmem_stall)
                   ? (ret_flush_q ? S_FLUSH : S_RUN) : state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_RUN;
      ret_flush_q <= 1'b0;
      fcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      ret_flush_q <= ret_flush_d;
      fcnt_q      <= fcnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ret_flush_d = ret_flush_q;
    fcnt_d      = fcnt_q;
    flush_inc   = 1'b0;
    case (eff_state)
      S_RUN: begin
        state_d = S_RUN;
        if (dmem_stall) begin
          state_d     = S_FREEZE;
          ret_flush_d = 1'b0;
        end else if (halt_ex) begin
          state_d = S_HALT;
        end else if (branch_taken_ex) begin
          flush_inc = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            fcnt_d  = FC_LOAD;
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (dmem_stall) begin
          state_d     = S_FREEZE;
          ret_flush_d = 1'b1;
        end else begin
          fcnt_d  = fcnt_q - FC_W'(1);
          state_d = (fcnt_q == FC_W'(1)) ? S_RUN : S_FLUSH;
        end
      end
      S_FREEZE: state_d = S_FREEZE;
      S_HALT:   state_d = S_HALT;
    endcase
  end

  always_comb begin
    stall_PC   = 1'b0;
    stall_FD   = 1'b0;
    flush_FD   = 1'b0;
    insert_NOP = 1'b0;
    freeze_DE  = 1'b0;
    if (rst) begin
      case (eff_state)
        S_RUN: begin
          if (dmem_stall) begin
            stall_PC  = 1'b1;
            stall_FD  = 1'b1;
            freeze_DE = 1'b1;
          end else if (halt_ex) begin
            stall_PC   = 1'b1;
            flush_FD   = 1'b1;
            insert_NOP = 1'b1;
          end else if (branch_taken_ex) begin
            flush_FD   = 1'b1;
            insert_NOP = 1'b1;
          end else if (raw) begin
            stall_PC   = 1'b1;
            stall_FD   = 1'b1;
            insert_NOP = 1'b1;
          end else if (imem_stall) begin
            stall_PC = 1'b1;
            flush_FD = 1'b1;
          end
        end
        S_FLUSH: begin
          if (dmem_stall) begin
            stall_PC  = 1'b1;
            stall_FD  = 1'b1;
            freeze_DE = 1'b1;
          end else begin
            flush_FD   = 1'b1;
            insert_NOP = 1'b1;
          end
        end
        S_FREEZE: begin
          stall_PC  = 1'b1;
          stall_FD  = 1'b1;
          freeze_DE = 1'b1;
        end
        S_HALT: begin
          stall_PC   = 1'b1;
          flush_FD   = 1'b1;
          insert_NOP = 1'b1;
        end
      endcase
    end
  end

  // HALT holds the PC but is not a counted stall
  assign stall_inc = stall_PC && (eff_state != S_HALT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_inc && (flush_cnt_q != {CNT_W{1'b1}}))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: three parameterisations driven in lockstep,
// directed scenarios plus random traffic against a cycle-level model.
module tb_hazard_stall_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       rs_valid, rt_valid;
  logic [2:0] rs_sel, rt_sel;
  logic       de_reg_write_en, de_mem_read, em_reg_write_en;
  logic [2:0] de_write_reg_sel, em_write_reg_sel;
  logic       branch_taken_ex, halt_ex, imem_stall, dmem_stall;

  logic        pc0, fd0, fl0, nop0, frz0;
  logic        pc1, fd1, fl1, nop1, frz1;
  logic        pc2, fd2, fl2, nop2, frz2;
  logic [15:0] sc0, fc0, sc2, fc2;
  logic [3:0]  sc1, fc1;

  // dut0: FORWARDING=1 FLUSH=2 W=16; dut1: FORWARDING=0 FLUSH=1 W=4; dut2: FORWARDING=1 FLUSH=3 W=16
  hazard_stall_ctrl #(.FORWARDING(1), .FLUSH_CYCLES(2), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst(rst), .rs_valid(rs_valid), .rs_sel(rs_sel), .rt_valid(rt_valid), .rt_sel(rt_sel),
    .de_reg_write_en(de_reg_write_en), .de_write_reg_sel(de_write_reg_sel), .de_mem_read(de_mem_read),
    .em_reg_write_en(em_reg_write_en), .em_write_reg_sel(em_write_reg_sel),
    .branch_taken_ex(branch_taken_ex), .halt_ex(halt_ex), .imem_stall(imem_stall), .dmem_stall(dmem_stall),
    .stall_PC(pc0), .stall_FD(fd0), .flush_FD(fl0), .insert_NOP(nop0), .freeze_DE(frz0),
    .stall_cnt(sc0), .flush_cnt(fc0));

  hazard_stall_ctrl #(.FORWARDING(0), .FLUSH_CYCLES(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .rs_valid(rs_valid), .rs_sel(rs_sel), .rt_valid(rt_valid), .rt_sel(rt_sel),
    .de_reg_write_en(de_reg_write_en), .de_write_reg_sel(de_write_reg_sel), .de_mem_read(de_mem_read),
    .em_reg_write_en(em_reg_write_en), .em_write_reg_sel(em_write_reg_sel),
    .branch_taken_ex(branch_taken_ex), .halt_ex(halt_ex), .imem_stall(imem_stall), .dmem_stall(dmem_stall),
    .stall_PC(pc1), .stall_FD(fd1), .flush_FD(fl1), .insert_NOP(nop1), .freeze_DE(frz1),
    .stall_cnt(sc1), .flush_cnt(fc1));

  hazard_stall_ctrl #(.FORWARDING(1), .FLUSH_CYCLES(3), .CNT_W(16)) u_dut2 (
    .clk(clk), .rst(rst), .rs_valid(rs_valid), .rs_sel(rs_sel), .rt_valid(rt_valid), .rt_sel(rt_sel),
    .de_reg_write_en(de_reg_write_en), .de_write_reg_sel(de_write_reg_sel), .de_mem_read(de_mem_read),
    .em_reg_write_en(em_reg_write_en), .em_write_reg_sel(em_write_reg_sel),
    .branch_taken_ex(branch_taken_ex), .halt_ex(halt_ex), .imem_stall(imem_stall), .dmem_stall(dmem_stall),
    .stall_PC(pc2), .stall_FD(fd2), .flush_FD(fl2), .insert_NOP(nop2), .freeze_DE(frz2),
    .stall_cnt(sc2), .flush_cnt(fc2));

  // Output vector order: {stall_PC, stall_FD, flush_FD, insert_NOP, freeze_DE}
  logic [4:0]  obs_o  [3];
  logic [15:0] obs_sc [3];
  logic [15:0] obs_fc [3];
  always_comb begin
    obs_o[0]  = {pc0, fd0, fl0, nop0, frz0};
    obs_o[1]  = {pc1, fd1, fl1, nop1, frz1};
    obs_o[2]  = {pc2, fd2, fl2, nop2, frz2};
    obs_sc[0] = sc0;
    obs_sc[1] = {12'd0, sc1};
    obs_sc[2] = sc2;
    obs_fc[0] = fc0;
    obs_fc[1] = {12'd0, fc1};
    obs_fc[2] = fc2;
  end

  localparam logic [4:0] O_IDLE   = 5'b00000;
  localparam logic [4:0] O_FREEZE = 5'b11001;
  localparam logic [4:0] O_HALT   = 5'b10110;
  localparam logic [4:0] O_FLUSH  = 5'b00110;
  localparam logic [4:0] O_RAW    = 5'b11010;
  localparam logic [4:0] O_IMEM   = 5'b10100;

  int fw   [3] = '{1, 0, 1};
  int fcyc [3] = '{2, 1, 3};
  int cmax [3] = '{65535, 15, 65535};

  // Model: pending bubbles, halted flag, counters
  int m_bub  [3];
  bit m_halt [3];
  int m_sc   [3];
  int m_fc   [3];

  int checks = 0;
  int errors = 0;

  function automatic bit hit(input logic [2:0] r);
    return (rs_valid && rs_sel == r) || (rt_valid && rt_sel == r);
  endfunction

  function automatic bit mdl_raw(input int k);
    bit lu;
    lu = de_reg_write_en && de_mem_read && hit(de_write_reg_sel);
    if (fw[k] != 0) return lu;
    return (de_reg_write_en && hit(de_write_reg_sel)) || (em_reg_write_en && hit(em_write_reg_sel));
  endfunction

  function automatic logic [4:0] mdl_out(input int k);
    if (!rst)            return O_IDLE;
    if (m_halt[k])       return O_HALT;
    if (dmem_stall)      return O_FREEZE;
    if (m_bub[k] > 0)    return O_FLUSH;
    if (halt_ex)         return O_HALT;
    if (branch_taken_ex) return O_FLUSH;
    if (mdl_raw(k))      return O_RAW;
    if (imem_stall)      return O_IMEM;
    return O_IDLE;
  endfunction

  task automatic mdl_reset_all();
    for (int k = 0; k < 3; k++) begin
      m_bub[k] = 0; m_halt[k] = 1'b0; m_sc[k] = 0; m_fc[k] = 0;
    end
  endtask

  task automatic mdl_step(input int k);
    if (!rst) begin
      m_bub[k] = 0; m_halt[k] = 1'b0; m_sc[k] = 0; m_fc[k] = 0;
    end else if (m_halt[k]) begin
      m_halt[k] = 1'b1;
    end else if (dmem_stall) begin
      if (m_sc[k] < cmax[k]) m_sc[k]++;
    end else if (m_bub[k] > 0) begin
      m_bub[k]--;
    end else if (halt_ex) begin
      m_halt[k] = 1'b1;
      if (m_sc[k] < cmax[k]) m_sc[k]++;
    end else if (branch_taken_ex) begin
      if (m_fc[k] < cmax[k]) m_fc[k]++;
      m_bub[k] = fcyc[k] - 1;
    end else if (mdl_raw(k) || imem_stall) begin
      if (m_sc[k] < cmax[k]) m_sc[k]++;
    end
  endtask

  task automatic tick();
    for (int k = 0; k < 3; k++) mdl_step(k);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_in();
    rs_valid = 0; rs_sel = 0; rt_valid = 0; rt_sel = 0;
    de_reg_write_en = 0; de_write_reg_sel = 0; de_mem_read = 0;
    em_reg_write_en = 0; em_write_reg_sel = 0;
    branch_taken_ex = 0; halt_ex = 0; imem_stall = 0; dmem_stall = 0;
  endtask

  task automatic apply_reset();
    clear_in();
    rst = 1'b0;
    mdl_reset_all();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    clear_in();
    rst = 1'b0;
    mdl_reset_all();
    dmem_stall = 1; halt_ex = 1; branch_taken_ex = 1; imem_stall = 1;
    @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (obs_o[k] !== O_IDLE) begin errors++; $display("FAIL reset_out dut%0d got %b expected %b", k, obs_o[k], O_IDLE); end
      checks++;
      if (obs_sc[k] !== 16'd0 || obs_fc[k] !== 16'd0) begin
        errors++; $display("FAIL reset_cnt dut%0d got %0d/%0d expected 0/0", k, obs_sc[k], obs_fc[k]);
      end
      checks++;
    end
  endtask

  task automatic test_load_use();
    apply_reset();
    de_reg_write_en = 1; de_write_reg_sel = 3'd3; de_mem_read = 1; rs_valid = 1; rs_sel = 3'd3;
    #1;
    if (obs_o[0] !== O_RAW) begin errors++; $display("FAIL load_use_stall got %b expected %b", obs_o[0], O_RAW); end
    checks++;
    tick();
    de_reg_write_en = 0; de_mem_read = 0; em_reg_write_en = 1; em_write_reg_sel = 3'd3;
    #1;
    if (obs_o[0] !== O_IDLE) begin errors++; $display("FAIL load_use_release got %b expected %b", obs_o[0], O_IDLE); end
    checks++;
    if (obs_sc[0] !== 16'd1) begin errors++; $display("FAIL load_use_cnt got %0d expected 1", obs_sc[0]); end
    checks++;
    tick();
  endtask

  task automatic test_em_raw();
    apply_reset();
    em_reg_write_en = 1; em_write_reg_sel = 3'd2; rt_valid = 1; rt_sel = 3'd2;
    for (int c = 0; c < 2; c++) begin
      #1;
      if (obs_o[0] !== O_IDLE) begin errors++; $display("FAIL em_raw_fwd c%0d got %b expected %b", c, obs_o[0], O_IDLE); end
      checks++;
      if (obs_o[1] !== O_RAW) begin errors++; $display("FAIL em_raw_nofwd c%0d got %b expected %b", c, obs_o[1], O_RAW); end
      checks++;
      tick();
    end
    rt_valid = 0;
    #1;
    if (obs_o[1] !== O_IDLE) begin errors++; $display("FAIL em_raw_clear got %b expected %b", obs_o[1], O_IDLE); end
    checks++;
    if (obs_sc[1] !== 16'd2) begin errors++; $display("FAIL em_raw_cnt got %0d expected 2", obs_sc[1]); end
    checks++;
    tick();
  endtask

  task automatic test_branch_flush();
    logic [4:0] exp0 [4];
    logic [4:0] exp2 [4];
    exp0 = '{O_FLUSH, O_FLUSH, O_IDLE, O_IDLE};
    exp2 = '{O_FLUSH, O_FLUSH, O_FLUSH, O_IDLE};
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      clear_in();
      branch_taken_ex = (c == 0);
      if (c == 1) begin
        de_reg_write_en = 1; de_write_reg_sel = 3'd4; de_mem_read = 1; rs_valid = 1; rs_sel = 3'd4;
      end
      #1;
      if (obs_o[0] !== exp0[c]) begin errors++; $display("FAIL flush2 c%0d got %b expected %b", c, obs_o[0], exp0[c]); end
      checks++;
      if (obs_o[2] !== exp2[c]) begin errors++; $display("FAIL flush3 c%0d got %b expected %b", c, obs_o[2], exp2[c]); end
      checks++;
      if (c == 1 && obs_o[1] !== O_RAW) begin errors++; $display("FAIL flush1_raw got %b expected %b", obs_o[1], O_RAW); end
      if (c == 1) checks++;
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      if (obs_fc[k] !== 16'd1) begin errors++; $display("FAIL flush_cnt dut%0d got %0d expected 1", k, obs_fc[k]); end
      checks++;
    end
    clear_in();
  endtask

  task automatic test_freeze_in_flush();
    logic [4:0] exp0 [7];
    logic [4:0] exp2 [7];
    exp0 = '{O_FLUSH, O_FREEZE, O_FREEZE, O_FREEZE, O_FLUSH, O_IDLE, O_IDLE};
    exp2 = '{O_FLUSH, O_FREEZE, O_FREEZE, O_FREEZE, O_FLUSH, O_FLUSH, O_IDLE};
    apply_reset();
    for (int c = 0; c < 7; c++) begin
      clear_in();
      branch_taken_ex = (c == 0);
      dmem_stall = (c >= 1 && c <= 3);
      #1;
      if (obs_o[0] !== exp0[c]) begin errors++; $display("FAIL freeze_flush2 c%0d got %b expected %b", c, obs_o[0], exp0[c]); end
      checks++;
      if (obs_o[2] !== exp2[c]) begin errors++; $display("FAIL freeze_flush3 c%0d got %b expected %b", c, obs_o[2], exp2[c]); end
      checks++;
      tick();
    end
    if (obs_sc[0] !== 16'd3 || obs_fc[0] !== 16'd1) begin
      errors++; $display("FAIL freeze_flush_cnt got %0d/%0d expected 3/1", obs_sc[0], obs_fc[0]);
    end
    checks++;
  endtask

  task automatic test_dmem_vs_branch();
    apply_reset();
    dmem_stall = 1; branch_taken_ex = 1;
    #1;
    for (int k = 0; k < 3; k++) begin
      if (obs_o[k] !== O_FREEZE) begin errors++; $display("FAIL dmem_wins dut%0d got %b expected %b", k, obs_o[k], O_FREEZE); end
      checks++;
    end
    tick();
    dmem_stall = 0;
    #1;
    if (obs_fc[0] !== 16'd0) begin errors++; $display("FAIL dmem_wins_cnt got %0d expected 0", obs_fc[0]); end
    checks++;
    for (int k = 0; k < 3; k++) begin
      if (obs_o[k] !== O_FLUSH) begin errors++; $display("FAIL branch_after dut%0d got %b expected %b", k, obs_o[k], O_FLUSH); end
      checks++;
    end
    tick();
    clear_in();
    #1;
    if (obs_fc[0] !== 16'd1) begin errors++; $display("FAIL branch_after_cnt got %0d expected 1", obs_fc[0]); end
    checks++;
    tick();
  endtask

  task automatic test_halt();
    apply_reset();
    halt_ex = 1;
    #1;
    if (obs_o[0] !== O_HALT) begin errors++; $display("FAIL halt_enter got %b expected %b", obs_o[0], O_HALT); end
    checks++;
    tick();
    halt_ex = 0; dmem_stall = 1; branch_taken_ex = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (obs_o[1] !== O_HALT) begin errors++; $display("FAIL halt_hold c%0d got %b expected %b", c, obs_o[1], O_HALT); end
      checks++;
      tick();
    end
    if (obs_sc[0] !== 16'd1 || obs_fc[0] !== 16'd0) begin
      errors++; $display("FAIL halt_cnt got %0d/%0d expected 1/0", obs_sc[0], obs_fc[0]);
    end
    checks++;
  endtask

  task automatic test_imem();
    apply_reset();
    imem_stall = 1;
    #1;
    if (obs_o[0] !== O_IMEM) begin errors++; $display("FAIL imem got %b expected %b", obs_o[0], O_IMEM); end
    checks++;
    tick();
    de_reg_write_en = 1; de_write_reg_sel = 3'd6; de_mem_read = 1; rt_valid = 1; rt_sel = 3'd6;
    #1;
    if (obs_o[0] !== O_RAW) begin errors++; $display("FAIL imem_vs_raw got %b expected %b", obs_o[0], O_RAW); end
    checks++;
    tick();
    clear_in();
    #1;
    if (obs_sc[0] !== 16'd2) begin errors++; $display("FAIL imem_cnt got %0d expected 2", obs_sc[0]); end
    checks++;
  endtask

  task automatic test_saturate_and_reset();
    apply_reset();
    em_reg_write_en = 1; em_write_reg_sel = 3'd5; rs_valid = 1; rs_sel = 3'd5;
    repeat (20) tick();
    #1;
    if (obs_sc[1] !== 16'd15) begin errors++; $display("FAIL stall_sat got %0d expected 15", obs_sc[1]); end
    checks++;
    if (obs_sc[0] !== 16'd0) begin errors++; $display("FAIL stall_fwd_none got %0d expected 0", obs_sc[0]); end
    checks++;
    clear_in();
    branch_taken_ex = 1;
    repeat (18) tick();
    #1;
    if (obs_fc[1] !== 16'd15) begin errors++; $display("FAIL flush_sat got %0d expected 15", obs_fc[1]); end
    checks++;
    clear_in();
    repeat (3) tick();
    dmem_stall = 1;
    repeat (2) tick();
    #1;
    if (obs_o[0] !== O_FREEZE) begin errors++; $display("FAIL pre_reset_freeze got %b expected %b", obs_o[0], O_FREEZE); end
    checks++;
    rst = 1'b0;
    mdl_reset_all();
    #1;
    for (int k = 0; k < 2; k++) begin
      if (obs_o[k] !== O_IDLE || obs_sc[k] !== 16'd0 || obs_fc[k] !== 16'd0) begin
        errors++; $display("FAIL mid_freeze_reset dut%0d got %b %0d %0d expected %b 0 0", k, obs_o[k], obs_sc[k], obs_fc[k], O_IDLE);
      end
      checks++;
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    clear_in();
    branch_taken_ex = 1;
    #1;
    if (obs_o[0] !== O_FLUSH) begin errors++; $display("FAIL post_reset_run got %b expected %b", obs_o[0], O_FLUSH); end
    checks++;
    tick();
    clear_in();
  endtask

  task automatic test_random();
    logic [4:0] eo;
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 59) == 0) begin
        rst = 1'b0;
        mdl_reset_all();
      end
      rs_valid         = 1'($urandom_range(0, 1));
      rs_sel           = 3'($urandom_range(0, 3));
      rt_valid         = 1'($urandom_range(0, 1));
      rt_sel           = 3'($urandom_range(0, 3));
      de_reg_write_en  = 1'($urandom_range(0, 1));
      de_write_reg_sel = 3'($urandom_range(0, 3));
      de_mem_read      = 1'($urandom_range(0, 1));
      em_reg_write_en  = 1'($urandom_range(0, 1));
      em_write_reg_sel = 3'($urandom_range(0, 3));
      branch_taken_ex  = ($urandom_range(0, 4) == 0);
      halt_ex          = ($urandom_range(0, 79) == 0);
      imem_stall       = ($urandom_range(0, 4) == 0);
      dmem_stall       = ($urandom_range(0, 5) == 0);
      #1;
      for (int k = 0; k < 3; k++) begin
        eo = mdl_out(k);
        if (obs_o[k] !== eo) begin errors++; $display("FAIL rand_out c%0d dut%0d got %b expected %b", c, k, obs_o[k], eo); end
        checks++;
        if (obs_sc[k] !== 16'(m_sc[k])) begin errors++; $display("FAIL rand_stall_cnt c%0d dut%0d got %0d expected %0d", c, k, obs_sc[k], m_sc[k]); end
        checks++;
        if (obs_fc[k] !== 16'(m_fc[k])) begin errors++; $display("FAIL rand_flush_cnt c%0d dut%0d got %0d expected %0d", c, k, obs_fc[k], m_fc[k]); end
        checks++;
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b0;
    clear_in();
    mdl_reset_all();
    test_reset();
    test_load_use();
    test_em_raw();
    test_branch_flush();
    test_freeze_in_flush();
    test_dmem_vs_branch();
    test_halt();
    test_imem();
    test_saturate_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
